sar_adc_ctrl: RTL
=================

# sar_adc_ctrl

Successive-approximation ADC controller, the receive-side counterpart of the on-chip DAC in the analog tile. It drives the trial code onto the capacitive DAC, samples the analog comparator through a synchroniser, resolves one bit per step MSB-first, and presents the final code with a one-cycle valid strobe. It sits between the tile's analog pins (comparator and track/hold) and the digital user I/O.

## Interface
Parameters:
- WIDTH, 8, resolution in bits.
- SAMPLE_CYCLES, 4, track/hold acquisition time in clk cycles. Minimum 1.
- SETTLE_CYCLES, 2, DAC settle time per bit before the synchroniser delay. Minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  block enable. When low, the FSM is forced to IDLE.
- start  in  1  conversion request, level-sampled in IDLE.
- cmp_in  in  1  asynchronous comparator output. High means Vin ≥ Vdac.
- sample  out  1  track/hold control. High during SAMPLE.
- dac_code  out  WIDTH  trial code driven to the DAC.
- busy  out  1  high in every state except IDLE.
- result  out  WIDTH  last completed conversion. Holds its value until the next completion.
- valid  out  1  single-cycle strobe that accompanies a new result.

## Operation
- Reset values: sample=0, dac_code=0, busy=0, result=0, valid=0, and the FSM is in IDLE.
- cmp_in passes through a 2-flop synchroniser. In the equations below, cmp_s is cmp_in delayed by 2 cycles.
- FSM states and transitions:
  - IDLE: if start=1 and ena=1, go to SAMPLE. Set bit index i=WIDTH-1 and accumulated code acc=0.
  - SAMPLE: sample=1 and dac_code=0 for SAMPLE_CYCLES cycles, then go to SETTLE.
  - SETTLE: dac_code = acc | (1<<i). Hold for SETTLE_CYCLES+2 cycles, then go to DECIDE.
  - DECIDE: one cycle. If cmp_s=1, set acc[i]=1; otherwise acc[i] stays 0. If i=0, go to DONE; otherwise decrement i and go to SETTLE.
  - DONE: one cycle. result<=acc, valid=1, dac_code holds the final code. Then go to IDLE.
- In IDLE, dac_code returns to 0.
- start while busy=1 is ignored and is neither queued nor flagged.
- If start is held high continuously, a new conversion begins on the cycle after DONE.
- ena low in any state: the FSM goes to IDLE on the next edge. dac_code goes to 0 and sample goes to 0. result is unchanged and no valid is produced.
- Reset mid-conversion: all outputs return to their reset values asynchronously. No partial result is ever committed.
- All code arithmetic is unsigned WIDTH bits with no carries. Only individual bits are set.

## Timing
- Conversion latency: L = 1 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+3) edges, counted from the edge that samples start=1 in IDLE to the edge that raises valid.
- With the default parameters, L = 45.
- valid is high for exactly 1 cycle. result changes on the same edge that raises valid.
- busy rises on the edge after start is sampled and falls on the edge after DONE.
- Back-to-back conversions give a throughput of one result every L+1 cycles.
- Outputs are all registered, with no combinational path from inputs to outputs.

## Configuration
- SAR_AVG4_EN defined:
  - Each accepted start runs 4 back-to-back conversions (SAMPLE→…→DECIDE, repeated) into a WIDTH+2-bit accumulator.
  - valid and result are produced only after the 4th conversion, with result = sum>>2 (truncated).
  - Latency is 4*(L-1)+1 edges (177 with defaults).
  - busy stays high across all 4 conversions. ena low or reset discards the partial sum.
- SAR_AVG4_EN undefined: single conversion per start as above, and no accumulator is built.

## Structure
- Package sar_adc_pkg holds:
  - the state enum (IDLE, SAMPLE, SETTLE, DECIDE, DONE);
  - the 2-flop synchroniser depth constant (2) used in the SETTLE count;
  - the averaging count constant (4) used when SAR_AVG4_EN is defined.
- Sub-module sar_cmp_sync is the 2-flop synchroniser for cmp_in. It takes clk and rst_n and resets to 0.
- The FSM, counters, acc and output registers live in sar_adc_ctrl.

## Test plan
- The bench comparator model is cmp_in = (vin ≥ dac_code), with vin an integer.
- Basic conversion: vin=0xA5, pulse start → valid at edge 45, result=0xA5. The dac_code sequence starts 0x80, 0xC0, 0xA0, 0xB0, …
- Extremes: vin=0x00 → result 0x00, and vin=0xFF → result 0xFF. busy is low on the cycle after valid.
- Start while busy: vin=0x3C, start held for 10 cycles, then start pulsed at cycle 20 → exactly one valid, result 0x3C. The next conversion requires a new start.
- Abort:
  - Drop ena at cycle 20 → busy=0 and dac_code=0 on the next cycle, no valid, result unchanged.
  - Assert rst_n=0 mid-conversion → all outputs 0 immediately. A following start with vin=0x5A gives 0x5A.
- Averaging (SAR_AVG4_EN): vin sequence 0x10, 0x12, 0x14, 0x17 (one per conversion) → a single valid at edge 177, result=0x13.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC controller.
// SAR_AVG4_EN (optional) selects four-conversion averaging in sar_adc_ctrl.
package sar_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

    localparam int SYNC_DEPTH = 2;
    localparam int AVG_COUNT  = 4;

endpackage

// File: rtl/sar_cmp_sync.sv
// Multi-flop synchroniser bringing the asynchronous comparator output into clk.
module sar_cmp_sync
    import sar_adc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic cmp_raw,
    output logic cmp_s
);

    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], cmp_raw};
        end
    end

    assign cmp_s = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: MSB-first bit resolution with registered outputs.
// Define SAR_AVG4_EN to average four conversions per start request.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    // SETTLE also covers the synchroniser delay so DECIDE sees the current trial.
    localparam int SETTLE_LEN = SETTLE_CYCLES + SYNC_DEPTH;
    localparam int CNT_MAX    = (SAMPLE_CYCLES > SETTLE_LEN) ? SAMPLE_CYCLES : SETTLE_LEN;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] dac_nxt;
    logic [WIDTH-1:0] res_val;
    logic             cmp_s;

    function automatic logic [WIDTH-1:0] bit_mask(input logic [IDX_W-1:0] b);
        return WIDTH'(1) << b;
    endfunction

`ifdef SAR_AVG4_EN
    localparam int AVG_W = $clog2(AVG_COUNT);
    localparam int SUM_W = WIDTH + AVG_W;

    logic [SUM_W-1:0] sum, sum_nxt;
    logic [AVG_W-1:0] conv, conv_nxt;

    function automatic logic [WIDTH-1:0] avg_trunc(input logic [SUM_W-1:0] s);
        return s[SUM_W-1:AVG_W];
    endfunction

    assign res_val = avg_trunc(sum);
`else
    assign res_val = acc;
`endif

    sar_cmp_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmp_raw (cmp_in),
        .cmp_s   (cmp_s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        acc_nxt   = acc;
`ifdef SAR_AVG4_EN
        sum_nxt   = sum;
        conv_nxt  = conv;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SAMPLE;
                    cnt_nxt   = '0;
                    idx_nxt   = IDX_W'(WIDTH - 1);
                    acc_nxt   = '0;
`ifdef SAR_AVG4_EN
                    sum_nxt   = '0;
                    conv_nxt  = '0;
`endif
                end
            end
            SAMPLE: begin
                if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_LEN - 1)) begin
                    state_nxt = DECIDE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DECIDE: begin
                if (cmp_s) begin
                    acc_nxt = acc | bit_mask(idx);
                end
                if (idx == '0) begin
`ifdef SAR_AVG4_EN
                    sum_nxt = sum + SUM_W'(acc_nxt);
                    if (conv == AVG_W'(AVG_COUNT - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SAMPLE;
                        conv_nxt  = conv + 1'b1;
                        cnt_nxt   = '0;
                        idx_nxt   = IDX_W'(WIDTH - 1);
                        acc_nxt   = '0;
                    end
`else
                    state_nxt = DONE;
`endif
                end else begin
                    idx_nxt   = idx - 1'b1;
                    state_nxt = SETTLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!ena) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        dac_nxt = '0;
        case (state_nxt)
            SETTLE, DECIDE: dac_nxt = acc_nxt | bit_mask(idx_nxt);
            DONE:           dac_nxt = acc_nxt;
            default:        dac_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sample   <= 1'b0;
            dac_code <= '0;
            busy     <= 1'b0;
            result   <= '0;
            valid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sample   <= (state_nxt == SAMPLE);
            dac_code <= dac_nxt;
            busy     <= (state_nxt != IDLE);
            valid    <= (state == DONE) && ena;
            if ((state == DONE) && ena) begin
                result <= res_val;
            end
        end
    end

    // Datapath registers are reloaded on every accepted start, so they need no reset.
    always_ff @(posedge clk) begin
        idx <= idx_nxt;
        acc <= acc_nxt;
`ifdef SAR_AVG4_EN
        sum  <= sum_nxt;
        conv <= conv_nxt;
`endif
    end

endmodule
